regfile_wb_scheduler: RTL and testbench

//  Owns the single write port of the 32x32 register file. After reset it

---
 rtl/regfile_wb_scheduler.sv | 101 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Register file write-port owner: zero-fills all registers after reset, then
// arbitrates ALU writeback and LSU load-return with an LSU starvation guard.
module regfile_wb_scheduler #(
    parameter int NUM_REGS     = 32,
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_valid,
    input  logic [$clog2(NUM_REGS)-1:0] alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    output logic                        alu_ready,
    input  logic                        lsu_valid,
    input  logic [$clog2(NUM_REGS)-1:0] lsu_rd,
    input  logic [XLEN-1:0]             lsu_data,
    output logic                        lsu_ready,
    output logic                        reg_write,
    output logic [$clog2(NUM_REGS)-1:0] write_reg,
    output logic [XLEN-1:0]             write_data,
    output logic                        init_busy
);

    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [STARVE_W-1:0] STARVE_MX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        RUN   = 2'b01
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    clr_cnt;
    logic [STARVE_W-1:0] starve_cnt;

    logic run;
    logic lsu_pri;
    logic alu_xfer;
    logic lsu_xfer;

    // Anything other than RUN (including unencoded values) behaves as CLEAR.
    assign run       = (state == RUN);
    assign init_busy = !run;

    always_comb begin
        lsu_pri   = lsu_valid && (starve_cnt == STARVE_MX);
        alu_ready = run && alu_valid && !lsu_pri;
        lsu_ready = run && lsu_valid && (lsu_pri || !alu_valid);
        alu_xfer  = alu_valid && alu_ready;
        lsu_xfer  = lsu_valid && lsu_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            starve_cnt <= '0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (alu_xfer) begin
                        reg_write  <= (alu_rd != '0);
                        write_reg  <= alu_rd;
                        write_data <= alu_data;
                    end else if (lsu_xfer) begin
                        reg_write  <= (lsu_rd != '0);
                        write_reg  <= lsu_rd;
                        write_data <= lsu_data;
                    end else begin
                        reg_write  <= 1'b0;
                    end

                    // Counts cycles the LSU waits behind the ALU; saturates.
                    if (lsu_xfer || !lsu_valid)
                        starve_cnt <= '0;
                    else if (alu_xfer && starve_cnt != STARVE_MX)
                        starve_cnt <= starve_cnt + 1'b1;
                end
                default: begin
                    reg_write  <= 1'b1;
                    write_reg  <= clr_cnt;
                    write_data <= '0;
                    starve_cnt <= '0;
                    if (clr_cnt == LAST_IDX) begin
                        state <= RUN;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        state   <= CLEAR;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: zero-fill sequencing, grant order,
// starvation override, rd=0 suppression and reset abort.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        init_busy;

    int unsigned n_tests;
    int unsigned n_fail;

    regfile_wb_scheduler #(
        .NUM_REGS     (32),
        .XLEN         (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .lsu_ready  (lsu_ready),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .init_busy  (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_clear_run(input string tag);
        for (int i = 0; i < 32; i++) begin
            step();
            check({tag, " we"}, 32'(reg_write), 32'd1);
            check({tag, " idx"}, 32'(write_reg), 32'(i));
            check({tag, " data"}, write_data, 32'd0);
            check({tag, " busy"}, 32'(init_busy), (i == 31) ? 32'd0 : 32'd1);
        end
        step();
        check({tag, " we after"}, 32'(reg_write), 32'd0);
        check({tag, " busy after"}, 32'(init_busy), 32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'hAAAA_0000;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd10;
        lsu_data  = 32'hBBBB_0000;

        // T1: reset state, ready held low during reset and zero-fill
        @(negedge clk);
        step();
        step();
        check("rst we", 32'(reg_write), 32'd0);
        check("rst idx", 32'(write_reg), 32'd0);
        check("rst data", write_data, 32'd0);
        check("rst busy", 32'(init_busy), 32'd1);
        check("rst alu_ready", 32'(alu_ready), 32'd0);
        check("rst lsu_ready", 32'(lsu_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check("clr alu_ready", 32'(alu_ready), 32'd0);
        check("clr lsu_ready", 32'(lsu_ready), 32'd0);
        check("clr first idx", 32'(write_reg), 32'd0);
        check("clr first we", 32'(reg_write), 32'd1);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        for (int i = 1; i < 32; i++) begin
            step();
            check("clr we", 32'(reg_write), 32'd1);
            check("clr idx", 32'(write_reg), 32'(i));
            check("clr data", write_data, 32'd0);
            check("clr busy", 32'(init_busy), (i == 31) ? 32'd0 : 32'd1);
        end
        step();
        check("run idle we", 32'(reg_write), 32'd0);
        check("run idle busy", 32'(init_busy), 32'd0);

        // T2: single ALU write
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        #1;
        check("t2 alu_ready", 32'(alu_ready), 32'd1);
        check("t2 lsu_ready", 32'(lsu_ready), 32'd0);
        step();
        check("t2 we", 32'(reg_write), 32'd1);
        check("t2 idx", 32'(write_reg), 32'd5);
        check("t2 data", write_data, 32'hDEAD_BEEF);
        alu_valid = 1'b0;
        step();
        check("t2 we drop", 32'(reg_write), 32'd0);
        check("t2 idx hold", 32'(write_reg), 32'd5);
        check("t2 data hold", write_data, 32'hDEAD_BEEF);

        // T3: both requesters held; LSU wins every 5th cycle
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 32'h0000_00A7;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd8;
        lsu_data  = 32'h0000_0055;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t3 alu_ready", 32'(alu_ready), (k == 4 || k == 9) ? 32'd0 : 32'd1);
            check("t3 lsu_ready", 32'(lsu_ready), (k == 4 || k == 9) ? 32'd1 : 32'd0);
            step();
            check("t3 idx", 32'(write_reg), (k == 4 || k == 9) ? 32'd8 : 32'd7);
            check("t3 data", write_data, (k == 4 || k == 9) ? 32'h55 : 32'hA7);
            check("t3 we", 32'(reg_write), 32'd1);
        end
        // starvation count clears when lsu_valid drops
        for (int k = 0; k < 3; k++) step();
        lsu_valid = 1'b0;
        step();
        lsu_valid = 1'b1;
        #1;
        check("t3 starve cleared", 32'(lsu_ready), 32'd0);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        step();

        // T4: LSU write to x0 accepted but suppressed
        lsu_valid = 1'b1;
        lsu_rd    = 5'd0;
        lsu_data  = 32'h0000_1234;
        #1;
        check("t4 lsu_ready", 32'(lsu_ready), 32'd1);
        step();
        check("t4 we", 32'(reg_write), 32'd0);
        check("t4 idx", 32'(write_reg), 32'd0);
        check("t4 data", write_data, 32'h0000_1234);
        lsu_valid = 1'b0;
        step();

        // T6: back-to-back ALU writes
        alu_valid = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            alu_rd   = 5'(r);
            alu_data = 32'h100 + 32'(r);
            step();
            check("t6 we", 32'(reg_write), 32'd1);
            check("t6 idx", 32'(write_reg), 32'(r));
            check("t6 data", write_data, 32'h100 + 32'(r));
        end

        // reset during a RUN transfer aborts the write
        alu_rd   = 5'd4;
        alu_data = 32'h0000_0104;
        rst_n    = 1'b0;
        step();
        alu_valid = 1'b0;
        check("run abort we", 32'(reg_write), 32'd0);
        check("run abort busy", 32'(init_busy), 32'd1);
        rst_n = 1'b1;

        // T5: reset mid-clear restarts zero-fill from index 0
        for (int i = 0; i <= 10; i++) step();
        check("t5 at idx10", 32'(write_reg), 32'd10);
        rst_n = 1'b0;
        step();
        check("t5 abort we", 32'(reg_write), 32'd0);
        check("t5 abort idx", 32'(write_reg), 32'd0);
        step();
        rst_n = 1'b1;
        check_clear_run("t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
